layer_sequencer: RTL and testbench
==================================

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 SHALL have parameter INPUT_SIZE, default 16, number of inputs per neuron.
REQ-002 SHALL have parameter NUM_NEURONS, default 10, number of neurons in the layer.
REQ-003 SHALL have parameter ADDR_W, default 12, weight-memory address width.
REQ-004 SHALL have parameter RELU, default 0; when 1, negative captured results are stored as 0.
REQ-005 SHALL have parameter TIMEOUT, default 64, maximum cycles to wait for n_done.
REQ-006 clk  in  1  clock, rising edge.
REQ-007 rstN  in  1  reset, asynchronous, active-low.
REQ-008 layer_start  in  1  request to evaluate one full layer.
REQ-009 layer_busy  out  1  high from the cycle after an accepted layer_start until layer_done or error.
REQ-010 layer_done  out  1  one-cycle pulse when all NUM_NEURONS results are stored.
REQ-011 layer_err  out  1  sticky timeout flag; cleared on the next accepted layer_start.
REQ-012 w_rd  out  1  weight-memory read strobe.
REQ-013 w_addr  out  ADDR_W  weight-memory read address.
REQ-014 w_data  in  16 signed  read data, valid exactly one cycle after w_rd.
REQ-015 n_start  out  1  one-cycle start pulse to the neuron MAC.
REQ-016 n_weights  out  INPUT_SIZE x 16 signed  weight vector presented to the neuron.
REQ-017 n_bias  out  16 signed  bias presented to the neuron.
REQ-018 n_done  in  1  neuron completion pulse, one cycle wide.
REQ-019 n_result  in  16 signed  neuron result, valid the cycle after n_done is high.
REQ-020 out_vec  out  NUM_NEURONS x 16 signed  stored layer results.

Function
REQ-021 SHALL implement states IDLE, LOAD, DRAIN, START, WAIT, CAPTURE, NEXT.
REQ-022 IDLE: layer_start high -> neuron index k=0, read count i=0, clear layer_err, go to LOAD; layer_start in any other state SHALL be ignored.
REQ-023 Memory layout SHALL be fixed: neuron k weight i at address k*(INPUT_SIZE+1)+i; bias at k*(INPUT_SIZE+1)+INPUT_SIZE.
REQ-024 LOAD: w_rd SHALL be high for exactly INPUT_SIZE+1 consecutive cycles, w_addr incrementing by 1 each cycle starting at k*(INPUT_SIZE+1).
REQ-025 Each w_data word SHALL be written the cycle after its read: words 0..INPUT_SIZE-1 go to n_weights[0..INPUT_SIZE-1], the final word goes to n_bias.
REQ-026 DRAIN: one cycle to capture the final (bias) word, then go to START.
REQ-027 START: n_start SHALL be high for exactly one cycle, then go to WAIT with the watchdog counter cleared.
REQ-028 n_weights and n_bias SHALL remain stable from START until the transition out of CAPTURE.
REQ-029 WAIT: n_done high -> CAPTURE; otherwise increment the watchdog.
REQ-030 Watchdog reaching TIMEOUT -> set layer_err, deassert layer_busy, return to IDLE, no layer_done pulse, out_vec entries k..NUM_NEURONS-1 left unchanged.
REQ-031 CAPTURE: sample n_result in this cycle (the cycle after n_done) into out_vec[k]; with RELU=1, n_result<0 stores 0.
REQ-032 NEXT: if k==NUM_NEURONS-1, pulse layer_done, deassert layer_busy, go to IDLE; else k<=k+1, go to LOAD.
REQ-033 n_start SHALL never be asserted while a previous neuron operation is outstanding (between START and CAPTURE).
REQ-034 w_rd SHALL be low outside LOAD.
REQ-035 Per-neuron latency from LOAD entry to CAPTURE SHALL be INPUT_SIZE+4 cycles plus the neuron's start-to-done latency.
REQ-036 An n_done pulse outside WAIT SHALL be ignored.

Reset
REQ-037 rstN low SHALL asynchronously force IDLE; clear k, i and the watchdog; drive layer_busy, layer_done, layer_err, w_rd, n_start to 0; w_addr, n_bias, every n_weights and every out_vec entry to 0.
REQ-038 Reset mid-layer SHALL abandon the operation; after release, no layer_done pulse and no n_start until a new layer_start.

Verification
REQ-039 INPUT_SIZE=16, NUM_NEURONS=2, memory neuron0 all weights 256 with bias 10, neuron1 all weights -256 with bias 0, behavioral neuron model -> out_vec follows the model, one layer_done pulse, 34 w_rd cycles in total.
REQ-040 RELU=1, neuron model returns -500 -> out_vec entry 0; RELU=0 -> -500 (16'hFE0C).
REQ-041 Neuron model never asserts n_done, TIMEOUT=64 -> layer_err=1 64 cycles after WAIT entry, layer_busy=0, no layer_done; the next layer_start clears layer_err.
REQ-042 layer_start held high throughout -> exactly one layer per IDLE visit, single n_start per neuron.
REQ-043 rstN pulsed low during WAIT of neuron 1 -> all outputs 0 immediately; after release, stays IDLE.
REQ-044 Spurious n_done during LOAD -> ignored; w_addr sequence k*17..k*17+16 unchanged.

Source files
------------

// File: rtl/layer_sequencer.sv
// Sequences one dense layer: streams each neuron's weights and bias from memory,
// runs the neuron MAC under a watchdog and stores the (optionally rectified) results.
module layer_sequencer #(
   parameter int unsigned INPUT_SIZE  = 16,
   parameter int unsigned NUM_NEURONS = 10,
   parameter int unsigned ADDR_W      = 12,
   parameter int unsigned RELU        = 0,
   parameter int unsigned TIMEOUT     = 64
) (
   input  logic                                 clk,
   input  logic                                 rstN,
   input  logic                                 layer_start,
   output logic                                 layer_busy,
   output logic                                 layer_done,
   output logic                                 layer_err,
   output logic                                 w_rd,
   output logic [ADDR_W-1:0]                    w_addr,
   input  logic signed [15:0]                   w_data,
   output logic                                 n_start,
   output logic [INPUT_SIZE-1:0][15:0]          n_weights,
   output logic signed [15:0]                   n_bias,
   input  logic                                 n_done,
   input  logic signed [15:0]                   n_result,
   output logic [NUM_NEURONS-1:0][15:0]         out_vec
);

   localparam int unsigned IW = $clog2(INPUT_SIZE + 1);
   localparam int unsigned KW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
   localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      StIdle, StLoad, StDrain, StStart, StWait, StCapture, StNext
   } state_e;

   state_e          state_q;
   logic [KW-1:0]   k_q;
   logic [IW-1:0]   i_q;
   logic [WW-1:0]   wd_q;
   logic            rd_q;
   logic [IW-1:0]   ridx_q;
   logic [15:0]     capture_val;

   always_comb begin
      capture_val = n_result;
      if (RELU != 0 && n_result < 0) capture_val = '0;
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q    <= StIdle;
         k_q        <= '0;
         i_q        <= '0;
         wd_q       <= '0;
         rd_q       <= 1'b0;
         ridx_q     <= '0;
         layer_busy <= 1'b0;
         layer_done <= 1'b0;
         layer_err  <= 1'b0;
         w_rd       <= 1'b0;
         w_addr     <= '0;
         n_start    <= 1'b0;
         n_weights  <= '0;
         n_bias     <= '0;
         out_vec    <= '0;
      end else begin
         layer_done <= 1'b0;
         // Read data returns one cycle after the strobe; track which word it is.
         rd_q       <= w_rd;
         ridx_q     <= i_q;
         if (rd_q) begin
            if (ridx_q == IW'(INPUT_SIZE)) begin
               n_bias <= w_data;
            end else begin
               for (int j = 0; j < int'(INPUT_SIZE); j++) begin
                  if (ridx_q == IW'(j)) n_weights[j] <= w_data;
               end
            end
         end

         case (state_q)
            StIdle: begin
               if (layer_start) begin
                  k_q        <= '0;
                  i_q        <= '0;
                  layer_err  <= 1'b0;
                  layer_busy <= 1'b1;
                  w_rd       <= 1'b1;
                  w_addr     <= '0;
                  state_q    <= StLoad;
               end
            end
            StLoad: begin
               if (i_q == IW'(INPUT_SIZE)) begin
                  w_rd    <= 1'b0;
                  state_q <= StDrain;
               end else begin
                  i_q    <= i_q + 1'b1;
                  w_addr <= w_addr + 1'b1;
               end
            end
            StDrain: begin
               n_start <= 1'b1;
               state_q <= StStart;
            end
            StStart: begin
               n_start <= 1'b0;
               wd_q    <= '0;
               state_q <= StWait;
            end
            StWait: begin
               if (n_done) begin
                  state_q <= StCapture;
               end else if (wd_q == WW'(TIMEOUT - 1)) begin
                  layer_err  <= 1'b1;
                  layer_busy <= 1'b0;
                  state_q    <= StIdle;
               end else begin
                  wd_q <= wd_q + 1'b1;
               end
            end
            StCapture: begin
               for (int j = 0; j < int'(NUM_NEURONS); j++) begin
                  if (k_q == KW'(j)) out_vec[j] <= capture_val;
               end
               state_q <= StNext;
            end
            StNext: begin
               if (k_q == KW'(NUM_NEURONS - 1)) begin
                  layer_done <= 1'b1;
                  layer_busy <= 1'b0;
                  state_q    <= StIdle;
               end else begin
                  // Layout is contiguous, so the next neuron's base follows the last bias.
                  k_q     <= k_q + 1'b1;
                  i_q     <= '0;
                  w_addr  <= w_addr + 1'b1;
                  w_rd    <= 1'b1;
                  state_q <= StLoad;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: 16-input, 2-neuron layer with a behavioral
// weight memory and neuron MAC, run side by side with RELU off and on.
module tb_layer_sequencer;

   localparam int IS = 16;
   localparam int NN = 2;

   logic clk = 1'b0;
   logic rstN = 1'b1;
   logic layer_start = 1'b0;
   logic signed [15:0] w_data = '0;
   logic mdl_done = 1'b0;
   logic spur_done = 1'b0;
   logic n_done;
   logic signed [15:0] n_result = '0;

   logic layer_busy, layer_done, layer_err, w_rd, n_start;
   logic [11:0] w_addr;
   logic [IS-1:0][15:0] n_weights;
   logic signed [15:0] n_bias;
   logic [NN-1:0][15:0] out_vec;

   logic r_busy, r_done, r_err, r_rd, r_start;
   logic [11:0] r_addr;
   logic [IS-1:0][15:0] r_weights;
   logic signed [15:0] r_bias;
   logic [NN-1:0][15:0] r_out;

   assign n_done = mdl_done | spur_done;

   always #5 clk = ~clk;

   layer_sequencer #(.INPUT_SIZE(IS), .NUM_NEURONS(NN), .ADDR_W(12), .RELU(0), .TIMEOUT(64))
   u_dut (
      .clk(clk), .rstN(rstN), .layer_start(layer_start), .layer_busy(layer_busy),
      .layer_done(layer_done), .layer_err(layer_err), .w_rd(w_rd), .w_addr(w_addr),
      .w_data(w_data), .n_start(n_start), .n_weights(n_weights), .n_bias(n_bias),
      .n_done(n_done), .n_result(n_result), .out_vec(out_vec)
   );

   layer_sequencer #(.INPUT_SIZE(IS), .NUM_NEURONS(NN), .ADDR_W(12), .RELU(1), .TIMEOUT(64))
   u_relu (
      .clk(clk), .rstN(rstN), .layer_start(layer_start), .layer_busy(r_busy),
      .layer_done(r_done), .layer_err(r_err), .w_rd(r_rd), .w_addr(r_addr),
      .w_data(w_data), .n_start(r_start), .n_weights(r_weights), .n_bias(r_bias),
      .n_done(n_done), .n_result(n_result), .out_vec(r_out)
   );

   // Weight memory: neuron0 weights 256 bias 10, neuron1 weights -256 bias 0.
   logic signed [15:0] mem [0:33];
   initial begin
      for (int j = 0; j < 34; j++) begin
         if (j < 16) mem[j] = 16'sd256;
         else if (j == 16) mem[j] = 16'sd10;
         else if (j < 33) mem[j] = -16'sd256;
         else mem[j] = 16'sd0;
      end
   end

   always @(posedge clk) begin
      if (w_rd) w_data <= (w_addr < 12'd34) ? mem[w_addr] : 16'sd0;
   end

   // Neuron model: mode 0 sums (w >>> 8) plus bias, mode 1 returns -500, mode 2 never finishes.
   int mode = 0;
   int mdl_cnt = 0;

   function automatic logic signed [15:0] neuron_value();
      int acc;
      acc = int'(n_bias);
      for (int j = 0; j < IS; j++) acc += int'($signed(n_weights[j])) >>> 8;
      return 16'(acc);
   endfunction

   always @(posedge clk) begin
      mdl_done <= 1'b0;
      if (mdl_cnt != 0) begin
         mdl_cnt <= mdl_cnt - 1;
         if (mdl_cnt == 1) begin
            mdl_done <= 1'b1;
            n_result <= (mode == 1) ? -16'sd500 : neuron_value();
         end
      end else if (n_start && mode != 2) begin
         mdl_cnt <= 3;
      end
   end

   // Passive monitors.
   int rd_cnt = 0, done_cnt = 0, ns_cnt = 0, addr_errs = 0, ovl_errs = 0;
   int exp_addr = 0;
   bit outstanding = 1'b0;

   always @(negedge clk) begin
      if (!layer_busy) begin
         exp_addr = 0;
         outstanding = 1'b0;
      end
      if (w_rd) begin
         rd_cnt++;
         if (int'(w_addr) != exp_addr) addr_errs++;
         exp_addr++;
      end
      if (layer_done) done_cnt++;
      if (n_start) begin
         ns_cnt++;
         if (outstanding) ovl_errs++;
         outstanding = 1'b1;
      end
      if (mdl_done) outstanding = 1'b0;
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      layer_start = 1'b1;
      @(negedge clk);
      layer_start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!layer_done && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk(tag, {31'd0, layer_done}, 32'd1);
   endtask

   int rd0, dn0, ns0, n;

   initial begin
      // Reset state
      #1 rstN = 1'b0;
      #3;
      chk("rst_busy", {31'd0, layer_busy}, 0);
      chk("rst_ctrl", {27'd0, layer_done, layer_err, w_rd, n_start, r_busy}, 0);
      chk("rst_addr", {20'd0, w_addr}, 0);
      chk("rst_data", {31'd0, (|out_vec) | (|n_weights) | (|n_bias)}, 0);
      repeat (2) @(negedge clk);
      rstN = 1'b1;

      // Nominal layer
      mode = 0;
      rd0 = rd_cnt; dn0 = done_cnt; ns0 = ns_cnt;
      pulse_start();
      chk("a_busy", {31'd0, layer_busy}, 1);
      wait_done("a_done");
      @(negedge clk);
      chk("a_rdcnt", rd_cnt - rd0, 34);
      chk("a_dones", done_cnt - dn0, 1);
      chk("a_nstart", ns_cnt - ns0, 2);
      chk("a_out0", {16'd0, out_vec[0]}, 32'h001A);
      chk("a_out1", {16'd0, out_vec[1]}, 32'hFFF0);
      chk("a_relu0", {16'd0, r_out[0]}, 32'h001A);
      chk("a_relu1", {16'd0, r_out[1]}, 32'h0000);
      chk("a_bias", {16'd0, n_bias}, 32'h0000);
      chk("a_w0", {16'd0, n_weights[0]}, 32'hFF00);
      chk("a_idle", {31'd0, layer_busy}, 0);

      // Negative result, spurious n_done during LOAD
      mode = 1;
      rd0 = rd_cnt; dn0 = done_cnt; ns0 = ns_cnt;
      pulse_start();
      repeat (4) @(negedge clk);
      spur_done = 1'b1;
      @(negedge clk);
      spur_done = 1'b0;
      wait_done("b_done");
      @(negedge clk);
      chk("b_out0", {16'd0, out_vec[0]}, 32'hFE0C);
      chk("b_out1", {16'd0, out_vec[1]}, 32'hFE0C);
      chk("b_relu0", {16'd0, r_out[0]}, 32'h0000);
      chk("b_rdcnt", rd_cnt - rd0, 34);
      chk("b_nstart", ns_cnt - ns0, 2);
      chk("b_addrseq", addr_errs, 0);

      // Watchdog timeout on neuron 0
      mode = 2;
      dn0 = done_cnt;
      pulse_start();
      n = 0;
      while (!n_start && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("c_nstart_seen", {31'd0, n_start}, 1);
      n = 0;
      while (!layer_err && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("c_err_latency", n, 65);
      chk("c_busy", {31'd0, layer_busy}, 0);
      repeat (3) @(negedge clk);
      chk("c_nodone", done_cnt - dn0, 0);
      chk("c_out0_kept", {16'd0, out_vec[0]}, 32'hFE0C);
      chk("c_out1_kept", {16'd0, out_vec[1]}, 32'hFE0C);
      chk("c_err_sticky", {31'd0, layer_err}, 1);
      mode = 0;
      pulse_start();
      chk("c_err_clear", {31'd0, layer_err}, 0);
      chk("c_rebusy", {31'd0, layer_busy}, 1);
      wait_done("c_done");
      @(negedge clk);
      chk("c_out0", {16'd0, out_vec[0]}, 32'h001A);

      // layer_start held high: one layer per IDLE visit
      dn0 = done_cnt; ns0 = ns_cnt;
      @(negedge clk);
      layer_start = 1'b1;
      @(negedge clk);
      wait_done("d_done1");
      @(negedge clk);
      wait_done("d_done2");
      layer_start = 1'b0;
      repeat (6) @(negedge clk);
      chk("d_dones", done_cnt - dn0, 2);
      chk("d_nstart", ns_cnt - ns0, 4);
      chk("d_idle", {31'd0, layer_busy}, 0);
      chk("d_overlap", ovl_errs, 0);

      // Reset during WAIT of neuron 1
      mode = 0;
      ns0 = ns_cnt;
      pulse_start();
      n = 0;
      while (ns_cnt - ns0 < 2 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("e_second_start", ns_cnt - ns0, 2);
      @(negedge clk);
      rstN = 1'b0;
      #1;
      chk("e_ctrl", {27'd0, layer_busy, layer_done, layer_err, w_rd, n_start}, 0);
      chk("e_data", {31'd0, (|out_vec) | (|n_weights) | (|n_bias) | (|w_addr)}, 0);
      @(negedge clk);
      rstN = 1'b1;
      dn0 = done_cnt; ns0 = ns_cnt;
      repeat (40) @(negedge clk);
      chk("e_nodone", done_cnt - dn0, 0);
      chk("e_nostart", ns_cnt - ns0, 0);
      chk("e_idle", {30'd0, layer_busy, w_rd}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
